// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV32I/RV64I immediate generator with an optional
// 2-entry skid buffer so decode can run at full rate under backpressure.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter bit SKID        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_I       = 3'b000,
    FMT_S       = 3'b001,
    FMT_B       = 3'b010,
    FMT_U       = 3'b011,
    FMT_J       = 3'b100,
    FMT_SHAMT   = 3'b101,
    FMT_NONE    = 3'b110,
    FMT_ILLEGAL = 3'b111
  } fmt_t;

  function automatic fmt_t decode_fmt(input logic [31:0] w);
    fmt_t f;
    case (w[6:0])
      7'b0010011: f = (w[14:12] == 3'b001 || w[14:12] == 3'b101) ? FMT_SHAMT : FMT_I;
      7'b0000011,
      7'b1100111,
      7'b1110011: f = FMT_I;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111,
      7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      7'b0110011,
      7'b0001111: f = FMT_NONE;
      default:    f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic [31:0]     raw32;
  logic [5:0]      shamt;

  // Every sign-extended format is first built as a 32-bit value and then
  // widened, so one cast covers both XLEN settings.
  always_comb begin
    dec_fmt = AUTO_DECODE ? 3'(decode_fmt(instr)) : imm_src;
    raw32   = '0;
    dec_imm = '0;
    dec_ill = 1'b0;
    shamt   = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    case (fmt_t'(dec_fmt))
      FMT_I: begin
        raw32   = {{20{instr[31]}}, instr[31:20]};
        dec_imm = XLEN'($signed(raw32));
      end
      FMT_S: begin
        raw32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_imm = XLEN'($signed(raw32));
      end
      FMT_B: begin
        raw32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_imm = XLEN'($signed(raw32));
      end
      FMT_U: begin
        raw32   = {instr[31:12], 12'b0};
        dec_imm = XLEN'($signed(raw32));
      end
      FMT_J: begin
        raw32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_imm = XLEN'($signed(raw32));
      end
      FMT_SHAMT:   dec_imm = XLEN'(shamt);
      FMT_NONE:    dec_imm = '0;
      FMT_ILLEGAL: dec_ill = 1'b1;
      default:     dec_imm = '0;
    endcase
  end

  logic            head_valid;
  logic [XLEN-1:0] head_imm;
  logic [2:0]      head_fmt;
  logic            head_ill;
  logic            tail_valid;
  logic [XLEN-1:0] tail_imm;
  logic [2:0]      tail_fmt;
  logic            tail_ill;
  logic            push;
  logic            pop;

  // With the skid buffer, readiness is the registered full flag only; rst
  // gates both sides so nothing transfers while reset is held.
  assign in_ready  = !rst && (SKID ? !tail_valid : (!head_valid || out_ready));
  assign out_valid = head_valid && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign imm_ext = head_imm;
  assign imm_fmt = head_fmt;
  assign illegal = head_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_imm   <= '0;
      head_fmt   <= 3'b000;
      head_ill   <= 1'b0;
      tail_valid <= 1'b0;
      tail_imm   <= '0;
      tail_fmt   <= 3'b000;
      tail_ill   <= 1'b0;
    end else if (SKID) begin
      if (tail_valid) begin
        if (pop) begin
          head_imm   <= tail_imm;
          head_fmt   <= tail_fmt;
          head_ill   <= tail_ill;
          tail_valid <= 1'b0;
        end
      end else if (head_valid) begin
        if (push && pop) begin
          head_imm <= dec_imm;
          head_fmt <= dec_fmt;
          head_ill <= dec_ill;
        end else if (push) begin
          tail_imm   <= dec_imm;
          tail_fmt   <= dec_fmt;
          tail_ill   <= dec_ill;
          tail_valid <= 1'b1;
        end else if (pop) begin
          head_valid <= 1'b0;
        end
      end else if (push) begin
        head_imm   <= dec_imm;
        head_fmt   <= dec_fmt;
        head_ill   <= dec_ill;
        head_valid <= 1'b1;
      end
    end else begin
      if (push) begin
        head_imm   <= dec_imm;
        head_fmt   <= dec_fmt;
        head_ill   <= dec_ill;
        head_valid <= 1'b1;
      end else if (pop) begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: manual-select XLEN=32 skid, auto-decode
// XLEN=32 skid, and auto-decode XLEN=64 single-register instances.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [2:0]  imm_src;

  logic        man_in_valid, man_in_ready, man_out_valid, man_out_ready, man_illegal;
  logic [31:0] man_imm;
  logic [2:0]  man_fmt;

  logic        a32_in_valid, a32_in_ready, a32_out_valid, a32_out_ready, a32_illegal;
  logic [31:0] a32_imm;
  logic [2:0]  a32_fmt;

  logic        a64_in_valid, a64_in_ready, a64_out_valid, a64_out_ready, a64_illegal;
  logic [63:0] a64_imm;
  logic [2:0]  a64_fmt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .SKID(1'b1)) u_man (
    .clk(clk), .rst(rst), .in_valid(man_in_valid), .in_ready(man_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(man_out_valid),
    .out_ready(man_out_ready), .imm_ext(man_imm), .imm_fmt(man_fmt),
    .illegal(man_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .SKID(1'b1)) u_a32 (
    .clk(clk), .rst(rst), .in_valid(a32_in_valid), .in_ready(a32_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(a32_out_valid),
    .out_ready(a32_out_ready), .imm_ext(a32_imm), .imm_fmt(a32_fmt),
    .illegal(a32_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .SKID(1'b0)) u_a64 (
    .clk(clk), .rst(rst), .in_valid(a64_in_valid), .in_ready(a64_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(a64_out_valid),
    .out_ready(a64_out_ready), .imm_ext(a64_imm), .imm_fmt(a64_fmt),
    .illegal(a64_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] m_imm;
    logic [2:0]  m_fmt;
    logic        m_ill;
    logic [31:0] a32_imm;
    logic [63:0] a64_imm;
    logic [2:0]  a_fmt;
    logic        a_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge after one accept.
  task automatic apply_stimulus(input logic [31:0] w, input logic [2:0] src);
    instr   = w;
    imm_src = src;
    man_in_valid = 1'b1;
    a32_in_valid = 1'b1;
    a64_in_valid = 1'b1;
    #1;
    check_output("man in_ready", man_in_ready, 1);
    check_output("a32 in_ready", a32_in_ready, 1);
    check_output("a64 in_ready", a64_in_ready, 1);
    @(negedge clk);
    man_in_valid = 1'b0;
    a32_in_valid = 1'b0;
    a64_in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 3'd0, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'h40515093, 3'd5, 32'h00000005, 3'd5, 1'b0, 32'h00000005, 64'h5, 3'd5, 1'b0};
    vecs[3]  = '{32'h80000037, 3'd3, 32'h80000000, 3'd3, 1'b0, 32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
    vecs[4]  = '{32'h00000000, 3'd7, 32'h00000000, 3'd7, 1'b1, 32'h00000000, 64'h0, 3'd7, 1'b1};
    vecs[5]  = '{32'h002081B3, 3'd6, 32'h00000000, 3'd6, 1'b0, 32'h00000000, 64'h0, 3'd6, 1'b0};
    vecs[6]  = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 3'd1, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    vecs[7]  = '{32'h001000EF, 3'd4, 32'h00000800, 3'd4, 1'b0, 32'h00000800, 64'h800, 3'd4, 1'b0};
    vecs[8]  = '{32'h03F09093, 3'd5, 32'h0000001F, 3'd5, 1'b0, 32'h0000001F, 64'h3F, 3'd5, 1'b0};
    vecs[9]  = '{32'hFFF00093, 3'd3, 32'hFFF00000, 3'd3, 1'b0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    vecs[10] = '{32'h12345017, 3'd3, 32'h12345000, 3'd3, 1'b0, 32'h12345000, 64'h12345000, 3'd3, 1'b0};
    vecs[11] = '{32'h00812083, 3'd0, 32'h00000008, 3'd0, 1'b0, 32'h00000008, 64'h8, 3'd0, 1'b0};
    vecs[12] = '{32'h0000000F, 3'd6, 32'h00000000, 3'd6, 1'b0, 32'h00000000, 64'h0, 3'd6, 1'b0};
    vecs[13] = '{32'h0000007F, 3'd7, 32'h00000000, 3'd7, 1'b1, 32'h00000000, 64'h0, 3'd7, 1'b1};
    vecs[14] = '{32'h00100073, 3'd0, 32'h00000001, 3'd0, 1'b0, 32'h00000001, 64'h1, 3'd0, 1'b0};
    vecs[15] = '{32'hFFC08067, 3'd0, 32'hFFFFFFFC, 3'd0, 1'b0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd0, 1'b0};

    rst = 1'b1;
    instr = '0;
    imm_src = '0;
    man_in_valid = 1'b0; a32_in_valid = 1'b0; a64_in_valid = 1'b0;
    man_out_ready = 1'b1; a32_out_ready = 1'b1; a64_out_ready = 1'b1;

    // Reset behaviour
    repeat (2) @(negedge clk);
    check_output("rst man in_ready", man_in_ready, 0);
    check_output("rst a32 in_ready", a32_in_ready, 0);
    check_output("rst a64 in_ready", a64_in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("post-rst out_valid", man_out_valid, 0);
    check_output("post-rst imm_ext", man_imm, 0);
    check_output("post-rst imm_fmt", man_fmt, 0);
    check_output("post-rst illegal", man_illegal, 0);
    check_output("post-rst man in_ready", man_in_ready, 1);
    check_output("post-rst a64 out_valid", a64_out_valid, 0);
    check_output("post-rst a64 imm_ext", a64_imm, 0);
    check_output("post-rst a64 in_ready", a64_in_ready, 1);

    // Table of single transactions, one-cycle latency each
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].instr, vecs[i].src);
      check_output($sformatf("v%0d man valid", i), man_out_valid, 1);
      check_output($sformatf("v%0d man imm", i), man_imm, vecs[i].m_imm);
      check_output($sformatf("v%0d man fmt", i), man_fmt, vecs[i].m_fmt);
      check_output($sformatf("v%0d man ill", i), man_illegal, vecs[i].m_ill);
      check_output($sformatf("v%0d a32 valid", i), a32_out_valid, 1);
      check_output($sformatf("v%0d a32 imm", i), a32_imm, vecs[i].a32_imm);
      check_output($sformatf("v%0d a32 fmt", i), a32_fmt, vecs[i].a_fmt);
      check_output($sformatf("v%0d a32 ill", i), a32_illegal, vecs[i].a_ill);
      check_output($sformatf("v%0d a64 valid", i), a64_out_valid, 1);
      check_output($sformatf("v%0d a64 imm", i), a64_imm, vecs[i].a64_imm);
      check_output($sformatf("v%0d a64 fmt", i), a64_fmt, vecs[i].a_fmt);
      check_output($sformatf("v%0d a64 ill", i), a64_illegal, vecs[i].a_ill);
    end
    @(negedge clk);
    check_output("drain man valid", man_out_valid, 0);
    check_output("drain a64 valid", a64_out_valid, 0);

    // Skid backpressure: A, B accepted, C held, then drained A B C with no bubble
    man_out_ready = 1'b0;
    man_in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'd0;
    #1 check_output("bp A in_ready", man_in_ready, 1);
    @(negedge clk);
    instr = 32'h80000037; imm_src = 3'd3;
    #1 check_output("bp B in_ready", man_in_ready, 1);
    @(negedge clk);
    instr = 32'h001000EF; imm_src = 3'd4;
    check_output("bp full in_ready", man_in_ready, 0);
    check_output("bp full valid", man_out_valid, 1);
    check_output("bp full imm A", man_imm, 32'hFFFFFFFF);
    @(negedge clk);
    check_output("bp hold in_ready", man_in_ready, 0);
    check_output("bp hold imm A", man_imm, 32'hFFFFFFFF);
    check_output("bp hold fmt A", man_fmt, 3'd0);
    man_out_ready = 1'b1;
    #1 check_output("bp ready independent", man_in_ready, 0);
    @(negedge clk);
    check_output("bp out B valid", man_out_valid, 1);
    check_output("bp out B imm", man_imm, 32'h80000000);
    check_output("bp out B fmt", man_fmt, 3'd3);
    check_output("bp C in_ready", man_in_ready, 1);
    @(negedge clk);
    man_in_valid = 1'b0;
    check_output("bp out C valid", man_out_valid, 1);
    check_output("bp out C imm", man_imm, 32'h00000800);
    check_output("bp out C fmt", man_fmt, 3'd4);
    @(negedge clk);
    check_output("bp empty valid", man_out_valid, 0);

    // Reset with a full buffer: stored entries must be discarded
    man_out_ready = 1'b0;
    man_in_valid = 1'b1; instr = 32'h12345017; imm_src = 3'd3;
    @(negedge clk);
    instr = 32'hFE112E23; imm_src = 3'd1;
    @(negedge clk);
    man_in_valid = 1'b0;
    check_output("rs full in_ready", man_in_ready, 0);
    check_output("rs full valid", man_out_valid, 1);
    rst = 1'b1;
    man_out_ready = 1'b1;
    #1;
    check_output("rs during valid", man_out_valid, 0);
    check_output("rs during in_ready", man_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rs after valid", man_out_valid, 0);
    check_output("rs after in_ready", man_in_ready, 1);
    @(negedge clk);
    check_output("rs no stale valid", man_out_valid, 0);
    check_output("rs no stale imm", man_imm, 0);
    man_in_valid = 1'b1; instr = 32'h00812083; imm_src = 3'd0;
    @(negedge clk);
    man_in_valid = 1'b0;
    check_output("rs new valid", man_out_valid, 1);
    check_output("rs new imm", man_imm, 32'h00000008);
    @(negedge clk);
    check_output("rs new drained", man_out_valid, 0);

    // Single-register mode: stall then replace in the same cycle as the pop
    a64_out_ready = 1'b0;
    a64_in_valid = 1'b1; instr = 32'h80000037; imm_src = 3'd0;
    @(negedge clk);
    instr = 32'h00100073;
    check_output("ns stall in_ready", a64_in_ready, 0);
    check_output("ns stall imm", a64_imm, 64'hFFFFFFFF80000000);
    check_output("ns stall fmt", a64_fmt, 3'd3);
    @(negedge clk);
    check_output("ns hold imm", a64_imm, 64'hFFFFFFFF80000000);
    a64_out_ready = 1'b1;
    #1 check_output("ns ready follows", a64_in_ready, 1);
    @(negedge clk);
    a64_in_valid = 1'b0;
    check_output("ns replace valid", a64_out_valid, 1);
    check_output("ns replace imm", a64_imm, 64'h1);
    check_output("ns replace fmt", a64_fmt, 3'd0);
    @(negedge clk);
    check_output("ns drained", a64_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
